// File: rtl/uart_tx_driver.sv
// Byte-level UART transmitter (8N1/8N2) fed by the UART data control stage.
// Serialises indata on txd, pulses driverFree once per byte, then holds off for GAP_CYCLES.
module uart_tx_driver #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       sysClk,
  input  logic       rst,
  input  logic       driverFlag,
  input  logic [7:0] indata,
  output logic       txd,
  output logic       driverFree,
  output logic       txBusy
);

  localparam int unsigned BIT_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(BIT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud_cnt == DIV_LAST);

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      txd        <= 1'b1;
      driverFree <= 1'b0;
      txBusy     <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
    end else begin
      driverFree <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (driverFlag) begin
            shreg    <= indata;
            state    <= START;
            txd      <= 1'b0;
            txBusy   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              txd     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // bit_idx is reused here to count stop bits
        STOP: begin
          txd <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx    <= '0;
              state      <= DONE;
              driverFree <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DONE: begin
          txd     <= 1'b1;
          gap_cnt <= '0;
          state   <= GAP;
        end

        GAP: begin
          txd <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
            txBusy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          txd    <= 1'b1;
          txBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// Self-checking bench for uart_tx_driver: a frame-arithmetic model checked every cycle on two
// instances (default 434-cycle bits, and a 4-cycle-bit 8N2 variant) plus literal waveform checks.
module tb_uart_tx_driver;

  localparam int unsigned BD_A  = 434;
  localparam int unsigned S_A   = 1;
  localparam int unsigned BD_B  = 4;
  localparam int unsigned S_B   = 2;
  localparam int unsigned G     = 2;
  localparam int unsigned TOT_A = (9 + S_A) * BD_A + G + 1;
  localparam int unsigned TOT_B = (9 + S_B) * BD_B + G + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flag_a = 1'b0, flag_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       txd_a, free_a, busy_a;
  logic       txd_b, free_b, busy_b;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #10 clk = ~clk;

  uart_tx_driver dut_a (
    .sysClk(clk), .rst(rst), .driverFlag(flag_a), .indata(data_a),
    .txd(txd_a), .driverFree(free_a), .txBusy(busy_a)
  );

  uart_tx_driver #(
    .CLK_FREQ(460800), .BAUD(115200), .STOP_BITS(S_B), .GAP_CYCLES(G)
  ) dut_b (
    .sysClk(clk), .rst(rst), .driverFlag(flag_b), .indata(data_b),
    .txd(txd_b), .driverFree(free_b), .txBusy(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected {txd, driverFree, txBusy} j edges after the load edge of byte b.
  function automatic logic [2:0] model_out(input logic active, input int unsigned j,
                                           input int unsigned bd, input int unsigned s,
                                           input logic [7:0] b);
    int unsigned k;
    if (!active)            return 3'b100;
    if (j < bd)             return 3'b001;
    if (j < 9 * bd) begin
      k = j / bd - 1;
      return {b[k], 1'b0, 1'b1};
    end
    if (j < (9 + s) * bd)   return 3'b101;
    if (j == (9 + s) * bd)  return 3'b111;
    return 3'b101;
  endfunction

  logic        act_a = 1'b0, act_b = 1'b0;
  int unsigned j_a = 0, j_b = 0;
  logic [7:0]  byte_a = '0, byte_b = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_a = 1'b0;
      j_a   = 0;
    end else if (!act_a) begin
      if (flag_a) begin
        act_a  = 1'b1;
        j_a    = 0;
        byte_a = data_a;
      end
    end else begin
      j_a++;
      if (j_a == TOT_A) act_a = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_b = 1'b0;
      j_b   = 0;
    end else if (!act_b) begin
      if (flag_b) begin
        act_b  = 1'b1;
        j_b    = 0;
        byte_b = data_b;
      end
    end else begin
      j_b++;
      if (j_b == TOT_B) act_b = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_outputs", int'({txd_a, free_a, busy_a}), int'(model_out(act_a, j_a, BD_A, S_A, byte_a)));
      chk("b_outputs", int'({txd_b, free_b, busy_b}), int'(model_out(act_b, j_b, BD_B, S_B, byte_b)));
    end
  end

  // One byte on instance A with literal mid-bit samples and pulse timing.
  task automatic send_a(input logic [7:0] b, input logic [9:0] frame, input logic change_mid);
    int unsigned nfree = 0;
    int unsigned free_at = 0;
    @(negedge clk);
    data_a = b;
    flag_a = 1'b1;
    @(posedge clk);
    for (int unsigned j = 0; j <= TOT_A + 2; j++) begin
      @(negedge clk);
      if (j == 0) begin
        flag_a = 1'b0;
        chk("a_busy_at_load", int'(busy_a), 1);
      end
      if (change_mid && j == 1500) data_a = 8'hFF;
      if ((j % BD_A) == BD_A / 2 && (j / BD_A) < 10)
        chk("a_line_bit", int'(txd_a), int'(frame[j / BD_A]));
      if (j == TOT_A) chk("a_busy_cleared", int'(busy_a), 0);
      if (free_a) begin
        nfree++;
        free_at = j;
      end
    end
    chk("a_free_count", int'(nfree), 1);
    chk("a_free_at", int'(free_at), 4340);
  endtask

  initial begin
    int unsigned low_seen, free_seen, stop_hi, pre_lo, restart_at, free_at;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle: nothing happens for 5000 cycles without driverFlag.
    low_seen = 0; free_seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!txd_a) low_seen++;
      if (free_a) free_seen++;
    end
    chk("idle_txd_low_cycles", int'(low_seen), 0);
    chk("idle_free_pulses", int'(free_seen), 0);
    chk("idle_busy", int'(busy_a), 0);

    send_a(8'hA5, 10'b1101001010, 1'b0);
    send_a(8'h3C, 10'b1001111000, 1'b1);

    // Reset 1500 cycles into a byte of zeros.
    @(negedge clk);
    data_a = 8'h00;
    flag_a = 1'b1;
    @(posedge clk);
    for (int unsigned j = 0; j < 1500; j++) begin
      @(negedge clk);
      if (j == 0) flag_a = 1'b0;
    end
    chk("pre_reset_txd", int'(txd_a), 0);
    #2 rst = 1'b1;
    #1;
    chk("reset_txd_async", int'(txd_a), 1);
    chk("reset_busy_async", int'(busy_a), 0);
    chk("reset_free_async", int'(free_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    free_seen = 0;
    for (int unsigned j = 0; j < TOT_A; j++) begin
      @(negedge clk);
      if (free_a) free_seen++;
    end
    chk("post_reset_no_free", int'(free_seen), 0);
    send_a(8'h5A, 10'b1010110100, 1'b0);

    // Instance B: 8N2, 4-cycle bits, byte 0x00 held back-to-back.
    @(negedge clk);
    data_b = 8'h00;
    flag_b = 1'b1;
    @(posedge clk);
    stop_hi = 0; pre_lo = 0; restart_at = 0; free_at = 0;
    for (int unsigned j = 0; j <= 2 * TOT_B + 4; j++) begin
      @(negedge clk);
      if (j < 36 && !txd_b) pre_lo++;
      if (j >= 36 && j < 44 && txd_b) stop_hi++;
      if (free_b && free_at == 0) free_at = j;
      if (j > 44 && !txd_b && restart_at == 0) restart_at = j;
      if (j == 48) flag_b = 1'b0;
    end
    chk("b_start_data_low", int'(pre_lo), 36);
    chk("b_stop_high_cycles", int'(stop_hi), 8);
    chk("b_free_at", int'(free_at), 44);
    chk("b_back_to_back_start", int'(restart_at), 48);

    // Randomised traffic on B; the per-cycle model comparison does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      flag_b = ($urandom_range(0, 3) != 0);
      data_b = 8'($urandom);
    end
    @(negedge clk);
    flag_b = 1'b0;
    repeat (TOT_B + 4) @(negedge clk);
    chk("b_final_idle_txd", int'(txd_b), 1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
